// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared states, sizes and header check for the instruction-memory loader
package imem_pkg;

  localparam int DEFAULT_DEPTH = 512;
  localparam int LEN_BYTES     = 2;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // A header is usable only if it names at least one word and fits the memory.
  function automatic logic len_ok(input logic [15:0] n, input int depth);
    return (n != 16'd0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, memory write port and status out
interface imem_loader_if;

  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        busy;
  logic        core_en;
  logic        err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, we, wa, wd, busy, core_en, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, we, wa, wd, busy, core_en, err
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word assembly
module byte_packer
  import imem_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    accept_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic [1:0]              byte_idx_o,
  output logic                    full_o
);

  localparam int IW = $clog2(WORD_BYTES);

  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    full_q, full_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
      full_d = 1'b0;
    end else if (accept_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d  = idx_q + 1'b1;
      // full stays up until the next byte starts a new word
      full_d = (idx_q == IW'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign word_o     = word_q;
  assign byte_idx_o = idx_q;
  assign full_o     = full_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, XOR-checksummed image into instruction memory
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [0:0]  len_cnt_q, len_cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;

  logic        ready;
  logic        accept;
  logic        start_ok;
  logic [31:0] pk_word;
  logic [1:0]  pk_idx;
  logic        pk_full;

  assign ready    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept   = ready && bus.byte_valid;
  assign start_ok = bus.start &&
                    ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

  byte_packer u_packer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (start_ok),
    .accept_i   (accept && (state_q == S_DATA)),
    .byte_i     (bus.byte_data),
    .word_o     (pk_word),
    .byte_idx_o (pk_idx),
    .full_o     (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    if (start_ok) begin
      len_d     = '0;
      len_cnt_d = '0;
      idx_d     = '0;
      csum_d    = '0;
    end else begin
      if ((state_q == S_LEN) && accept) begin
        len_d[8*len_cnt_q +: 8] = bus.byte_data;
        len_cnt_d               = len_cnt_q + 1'b1;
      end
      if ((state_q == S_DATA) && accept) csum_d = csum_q ^ bus.byte_data;
      if (state_q == S_WRITE)            idx_d  = idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      len_cnt_q <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
    end else begin
      len_q     <= len_d;
      len_cnt_q <= len_cnt_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
    end
  end

  // len_d already holds the complete count in the cycle the last length byte arrives
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN;
      S_LEN: if (accept && (len_cnt_q == 1'(LEN_BYTES - 1)))
               state_d = len_ok(len_d, DEPTH) ? S_DATA : S_ERR;
      S_DATA: if (accept && (pk_idx == 2'(WORD_BYTES - 1))) state_d = S_WRITE;
      S_WRITE: state_d = ((idx_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
      S_CSUM: if (accept) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = ready;
    bus.busy       = (state_q == S_LEN) || (state_q == S_DATA) ||
                     (state_q == S_WRITE) || (state_q == S_CSUM);
    bus.core_en    = (state_q == S_DONE);
    bus.err        = (state_q == S_ERR);
    bus.we         = 1'b0;
    bus.wa         = '0;
    bus.wd         = '0;
    if ((state_q == S_WRITE) && pk_full) begin
      bus.we = 1'b1;
      bus.wa = {14'd0, idx_q, 2'b00};
      bus.wd = pk_word;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 512;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected-write queue
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got wa=%h wd=%h expected no write", bus.wa, bus.wd);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_wa", bus.wa, e.wa);
          chk("write_wd", bus.wd, e.wd);
        end
      end else begin
        chk("idle_wa_wd_zero", bus.wa | bus.wd, 32'h0);
      end
    end
  end

  // Reference: decode the stream as header, words, checksum.
  function automatic void model(input bq_t s, output bit ok, output int nsend);
    int n;
    logic [7:0] cs;
    n  = int'(s[0]) + int'(s[1]) * 256;
    cs = 8'h00;
    if (n == 0 || n > DEPTH) begin
      ok    = 1'b0;
      nsend = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.wa = 32'(4 * i);
      e.wd = 32'h0;
      for (int k = 0; k < 4; k++) begin
        e.wd = e.wd | (32'(s[2 + 4*i + k]) << (8 * k));
        cs   = cs ^ s[2 + 4*i + k];
      end
      exp_q.push_back(e);
    end
    ok    = (s[2 + 4*n] == cs);
    nsend = 3 + 4*n;
  endfunction

  function automatic bq_t build(input int n, input bit good);
    bq_t s;
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      s.push_back(b);
    end
    s.push_back(good ? cs : (cs ^ 8'(1 + $urandom_range(0, 254))));
    return s;
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse);
    bit acc = 1'b0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 100 && !acc; t++) begin
      if (pulse && $urandom_range(0, 2) == 0) bus.start = 1'b1;
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: got byte_ready=0 for 100 cycles expected acceptance of %h", b);
    end
  endtask

  task automatic wait_end(input string name, input bit ok);
    int t = 0;
    @(negedge clk);
    while (!(bus.core_en || bus.err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_core_en"}, 32'(bus.core_en), 32'(ok));
    chk({name, "_err"}, 32'(bus.err), 32'(!ok));
    chk({name, "_busy"}, 32'(bus.busy), 32'h0);
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_load(input bq_t s, input bit gaps, input bit pulse, input string name);
    bit ok;
    int nsend;
    model(s, ok, nsend);
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      send_byte(s[i], gaps, pulse && i >= 3);
      if (i == 1 && nsend == 2) begin
        @(negedge clk);
        chk({name, "_err_after_len"}, 32'(bus.err), 32'h1);
      end
    end
    wait_end(name, ok);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(bus.busy), 32'h0);
    chk({name, "_core_en"}, 32'(bus.core_en), 32'h0);
    chk({name, "_err"}, 32'(bus.err), 32'h0);
    chk({name, "_we"}, 32'(bus.we), 32'h0);
    chk({name, "_byte_ready"}, 32'(bus.byte_ready), 32'h0);
    chk({name, "_wa"}, bus.wa, 32'h0);
    chk({name, "_wd"}, bus.wd, 32'h0);
  endtask

  initial begin
    bq_t basic;
    bq_t s;
    basic = '{8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'hB3};
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    run_load(basic, 1'b0, 1'b0, "basic");
    s = '{8'h00, 8'h00};
    run_load(s, 1'b0, 1'b0, "zero_len");
    s = '{8'h01, 8'h02};
    run_load(s, 1'b0, 1'b0, "oversize");
    run_load(build(2, 1'b0), 1'b0, 1'b0, "bad_csum");

    // Abandon a load after two data bytes; nothing may be written.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(basic[i], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    run_load(basic, 1'b0, 1'b0, "after_reset");

    run_load(basic, 1'b1, 1'b1, "gaps_start");
    run_load(build(DEPTH, 1'b1), 1'b0, 1'b0, "full_depth");
    for (int r = 0; r < 8; r++) begin
      run_load(build($urandom_range(1, 6), $urandom_range(0, 1) == 1), 1'b1, 1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 512, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle load request.
REQ-005 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-006 SHALL have port byte_data  input  8  incoming byte stream.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port wa  output  32  byte address of the write, word-aligned; the memory indexes by wa[31:2].
REQ-010 SHALL have port wd  output  32  write data word.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port core_en  output  1  image loaded and checked; the core may fetch.
REQ-013 SHALL have port err  output  1  load failed.

Function
REQ-014 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both 1; byte_valid may drop between bytes with no loss or duplication.
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, CSUM, DONE and ERR.
REQ-016 SHALL move from IDLE, DONE or ERR to LEN on start, clearing the word count, word index, byte index, checksum, core_en and err.
REQ-017 SHALL ignore start in LEN, DATA, WRITE and CSUM.
REQ-018 SHALL assert byte_ready only in LEN, DATA and CSUM.
REQ-019 SHALL assert busy in LEN, DATA, WRITE and CSUM.
REQ-020 In LEN, SHALL take two bytes as a little-endian 16-bit word count N.
REQ-021 SHALL go to ERR in the cycle after the second length byte when N==0 or N>DEPTH, otherwise to DATA.
REQ-022 In DATA, SHALL assemble 4 bytes little-endian into a word (first byte is bits [7:0]) and XOR each data byte into an 8-bit checksum.
REQ-023 After the 4th byte is accepted, SHALL enter WRITE for exactly one cycle with we=1, wa={index,2'b00} zero-extended to 32 bits, and wd set to the assembled word.
REQ-024 SHALL increment the word index after WRITE, then go to CSUM when the index equals N, else back to DATA.
REQ-025 In CSUM, SHALL take one byte and go to DONE if it equals the running checksum, else to ERR.
REQ-026 SHALL hold core_en=1 only in DONE and err=1 only in ERR.
REQ-027 SHALL drive we=0, wa=0 and wd=0 outside WRITE.
REQ-028 SHALL NOT retract words already written to memory when a later error occurs.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, enter IDLE with busy, core_en, err, we and byte_ready at 0, and wa, wd, counters and checksum at 0.
REQ-030 SHALL abandon any load on reset mid-operation; the next load requires a new start.
REQ-031 SHALL give rst priority over start.

Structure
REQ-032 SHALL place the state enumeration, the default DEPTH, and the LEN_BYTES=2 and WORD_BYTES=4 constants in shared package imem_pkg.
REQ-033 SHALL implement byte-to-word assembly in sub-module byte_packer (inputs: byte, accept strobe, clear; outputs: word, byte index, full flag).

Verification
REQ-034 Bench SHALL cover a basic load: start, bytes 01 00 33 E2 62 00 B3 -> one write we=1, wa=0x0, wd=0x0062E233; then core_en=1, err=0.
REQ-035 Bench SHALL cover a zero-length header: bytes 00 00 -> err=1 one cycle after the second byte, no write, core_en=0.
REQ-036 Bench SHALL cover an oversize header: bytes 01 02 (N=513, DEPTH=512) -> err=1, no write.
REQ-037 Bench SHALL cover a two-word load with a bad checksum: N=2, 8 data bytes, wrong checksum byte -> writes at wa=0x0 and 0x4 occur, then err=1, core_en=0.
REQ-038 Bench SHALL cover reset mid-DATA: rst asserted after 2 data bytes -> IDLE next cycle with all outputs 0; a fresh start with the REQ-034 stream completes correctly.
REQ-039 Bench SHALL cover back-pressure and gaps: byte_valid toggled randomly plus start pulsed during DATA -> identical writes to REQ-034 and start ignored.
